seq_det_param: RTL and testbench
================================

Name: seq_det_param

Overview:
- Parametrised serial pattern detector for single-bit streams; successor to the fixed 3-bit Moore sequence detectors in the FSM library.
- Pattern width is set by parameter; the pattern value itself is a run-time input.
- Supports overlapping and non-overlapping detection, qualified input bits (din_vld), and an optional saturating match counter.
- Sits between a serial bit source and control logic that consumes match pulses.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the match counter (used only when SEQ_DET_CNT_EN is defined).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- din_vld  input  1  din is sampled only when high
- din  input  1  serial data bit
- pattern  input  PAT_W  target pattern; pattern[PAT_W-1] is the first bit received
- mode_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
- clr_cnt  input  1  synchronous clear of match_cnt
- dout  output  1  registered match pulse (Moore)
- match_cnt  output  CNT_W  number of matches, saturating

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: dout=0, match_cnt=0, hist=0, fill=0, state=IDLE.
- rst has priority over all other inputs. Asserting rst mid-stream discards partial history; detection restarts from an empty window.
- Internal storage:
  - hist[PAT_W-1:0]: shift register holding the most recent bits; newest bit at bit 0.
  - fill[$clog2(PAT_W+1)-1:0]: number of valid bits in hist, saturating at PAT_W.
- State machine (registered state):
  - IDLE: fill=0. On din_vld -> FILL, or -> HUNT if PAT_W bits are now held (never true, since PAT_W>=2).
  - FILL: 0<fill<PAT_W. Each din_vld shifts in din and increments fill. Go to HUNT when fill reaches PAT_W.
  - HUNT: window full. Each din_vld shifts in din; fill stays at PAT_W.
  - Match in non-overlap mode -> IDLE with fill=0 and hist=0.
  - Match in overlap mode -> stay in HUNT.
- Match condition, evaluated on a din_vld cycle:
  - (fill == PAT_W-1, or fill == PAT_W) AND {hist[PAT_W-2:0], din} == pattern.
  - pattern and mode_ovl are sampled in the same cycle.
- dout timing:
  - dout goes high for exactly one clk in the cycle after the clock edge that accepted the completing bit (latency 1).
  - dout is 0 in every other cycle, including cycles following a din_vld=0 cycle.
- din_vld=0: hist, fill and state hold; dout goes to 0 on the next edge.
- Changing pattern or mode_ovl mid-stream is legal. It takes effect on the next din_vld cycle; history is not flushed.
- No default-state lockup: illegal state encodings go to IDLE on the next edge.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined: match_cnt increments by 1 on each match and saturates at 2^CNT_W-1. clr_cnt=1 forces match_cnt to 0 on the next edge; clr_cnt has priority over a simultaneous match (result 0). match_cnt updates in the same edge that sets dout.
- Undefined: counter logic is not instantiated, match_cnt is tied to 0, and clr_cnt is ignored.

Test Plan:
1. PAT_W=3, pattern=3'b011, mode_ovl=0, din_vld=1, din stream 0,1,1,0,1,1 -> dout pulses one cycle after the 3rd and the 6th bit; match_cnt=2.
2. pattern=3'b101, stream 1,0,1,0,1. mode_ovl=1 -> dout pulses after bits 3 and 5. mode_ovl=0 -> single pulse after bit 3; bits 4-5 refill the window with no match.
3. pattern=3'b011, stream 0,1,(din_vld=0 for 3 cycles),1 -> no pulse during the gap; dout=1 one cycle after the final valid bit.
4. Stream 0,1, then rst=1 for one cycle, then 1,0,1,1 -> no match on the first 1 after reset; a single match after the last 1; dout=0 and match_cnt=0 during and right after reset.
5. SEQ_DET_CNT_EN defined, CNT_W=2, pattern=3'b111, overlap, nine 1s -> 7 matches, match_cnt saturates at 3. clr_cnt asserted together with a match -> match_cnt=0.
6. PAT_W=8, pattern=8'hA5, random 500-bit stream with random din_vld and mode_ovl toggling -> dout matches the scoreboard model cycle-for-cycle.

Source files
------------

// File: rtl/seq_det_param.sv
// ----------------------------------------------------------------------------
// seq_det_param
// Parametrised serial pattern detector for a single-bit stream. The pattern
// width is fixed by PAT_W; the pattern value is a run-time input. Detection
// can overlap (window keeps sliding after a match) or not (window is emptied
// after a match). Input bits are qualified by din_vld.
//
// Optional feature (macro SEQ_DET_CNT_EN): a saturating match counter with
// synchronous clear. When the macro is undefined, match_cnt is tied to 0 and
// clr_cnt is ignored.
//
// Parameters
//   PAT_W     pattern length in bits, 2..16
//   CNT_W     match counter width
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   din_vld    in   din is sampled only when high
//   din        in   serial data bit
//   pattern    in   [PAT_W-1:0] target; pattern[PAT_W-1] is the first bit
//   mode_ovl   in   1 = overlapping, 0 = non-overlapping detection
//   clr_cnt    in   synchronous clear of match_cnt
//   dout       out  registered one-cycle match pulse
//   match_cnt  out  [CNT_W-1:0] saturating match count
//
// State table
//   state | meaning
//   IDLE  | window empty, fill = 0
//   FILL  | window partly loaded, 0 < fill < PAT_W
//   HUNT  | window full, fill = PAT_W, comparing every valid bit
// ----------------------------------------------------------------------------
module seq_det_param #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             mode_ovl,
    input  logic             clr_cnt,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        HUNT = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              r_dout;
    logic              w_match;
    logic [PAT_W-1:0]  w_window;
    logic              w_unused_hist_msb;

    // Candidate window: the stored history with the incoming bit appended.
    // The oldest stored bit falls off, so the history MSB is never compared.
    assign w_window          = {r_hist[PAT_W-2:0], din};
    assign w_unused_hist_msb = r_hist[PAT_W-1];

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_match     = 1'b0;

        case (r_state)
            IDLE: begin
                if (din_vld) begin
                    w_hist_nxt  = w_window;
                    w_fill_nxt  = FILL_W'(1);
                    w_state_nxt = FILL;
                end
            end

            FILL: begin
                if (din_vld) begin
                    w_hist_nxt = w_window;
                    w_fill_nxt = r_fill + FILL_W'(1);
                    w_match    = (r_fill == FILL_LAST) && (w_window == pattern);
                    if (w_fill_nxt == FILL_FULL) begin
                        w_state_nxt = HUNT;
                    end
                end
            end

            HUNT: begin
                if (din_vld) begin
                    w_hist_nxt = w_window;
                    w_match    = (r_fill == FILL_FULL) && (w_window == pattern);
                end
            end

            default: begin
                // Unused encoding: recover to an empty window.
                w_state_nxt = IDLE;
                w_hist_nxt  = '0;
                w_fill_nxt  = '0;
            end
        endcase

        // Non-overlapping: a match consumes the whole window.
        if (w_match && !mode_ovl) begin
            w_state_nxt = IDLE;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_dout  <= w_match;
        end
    end

    assign dout = r_dout;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a simultaneous match; count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_cnt;
    assign match_cnt    = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// ----------------------------------------------------------------------------
// tb_seq_det_param
// Self-checking bench for seq_det_param. Two instances: PAT_W=3/CNT_W=2 for
// the directed streams and PAT_W=8 for a long random stream. Each cycle a
// behavioural model (bit count since the window was last emptied plus a
// shifted integer of received bits) predicts dout and match_cnt; the
// prediction is queued when stimulus is driven and popped after the edge.
// ----------------------------------------------------------------------------
module tb_seq_det_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, vld3, din3, ovl3, clr3;
    logic [2:0] pat3;
    logic       dout3;
    logic [1:0] cnt3;

    logic       rst8, vld8, din8, ovl8, clr8;
    logic [7:0] pat8;
    logic       dout8;
    logic [7:0] cnt8;

    seq_det_param #(.PAT_W(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst3), .din_vld(vld3), .din(din3), .pattern(pat3),
        .mode_ovl(ovl3), .clr_cnt(clr3), .dout(dout3), .match_cnt(cnt3)
    );

    seq_det_param #(.PAT_W(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst8), .din_vld(vld8), .din(din8), .pattern(pat8),
        .mode_ovl(ovl8), .clr_cnt(clr8), .dout(dout8), .match_cnt(cnt8)
    );

    typedef struct {
        int dout;
        int cnt;
    } exp_t;

    exp_t  q3[$];
    exp_t  q8[$];

    int    n_chk  = 0;
    int    n_pass = 0;
    string tag    = "rst";

    int    m3_bits, m3_n, m3_cnt;
    int    m8_bits, m8_n, m8_cnt;
    int    pulses3, pulses8;

    int    s1[6] = '{0, 1, 1, 0, 1, 1};
    int    s2[5] = '{1, 0, 1, 0, 1};
    int    s4[4] = '{1, 0, 1, 1};

    task automatic check(input string t, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", t, got, exp);
    endtask

    task automatic model(input int w, input int pat, input int ovl,
                         input int vld, input int d, input int rv,
                         input int clr, input int cmax,
                         inout int bits, inout int n, inout int cnt,
                         output int dexp);
        int mask;
        mask = (1 << w) - 1;
        dexp = 0;
        if (rv != 0) begin
            bits = 0;
            n    = 0;
            cnt  = 0;
            return;
        end
        if (vld != 0) begin
            bits = ((bits << 1) | d) & mask;
            if (n < w) n++;
            if (n == w && bits == pat) begin
                dexp = 1;
                if (ovl == 0) begin
                    bits = 0;
                    n    = 0;
                end
            end
        end
`ifdef SEQ_DET_CNT_EN
        if (clr != 0) cnt = 0;
        else if (dexp == 1 && cnt < cmax) cnt++;
`else
        cnt = 0;
`endif
    endtask

    task automatic cyc(input int v3, input int d3, input int c3, input int r3,
                       input int v8, input int d8, input int c8, input int r8);
        exp_t e;
        int   dx;
        @(negedge clk);
        vld3 = 1'(v3); din3 = 1'(d3); clr3 = 1'(c3); rst3 = 1'(r3);
        vld8 = 1'(v8); din8 = 1'(d8); clr8 = 1'(c8); rst8 = 1'(r8);
        model(3, int'(pat3), int'(ovl3), v3, d3, r3, c3, 3,
              m3_bits, m3_n, m3_cnt, dx);
        e.dout = dx; e.cnt = m3_cnt; q3.push_back(e);
        model(8, int'(pat8), int'(ovl8), v8, d8, r8, c8, 255,
              m8_bits, m8_n, m8_cnt, dx);
        e.dout = dx; e.cnt = m8_cnt; q8.push_back(e);
        @(posedge clk);
        #1;
        e = q3.pop_front();
        check({tag, "_dout3"}, int'(dout3), e.dout);
        check({tag, "_cnt3"}, int'(cnt3), e.cnt);
        e = q8.pop_front();
        check({tag, "_dout8"}, int'(dout8), e.dout);
        check({tag, "_cnt8"}, int'(cnt8), e.cnt);
        if (dout3) pulses3++;
        if (dout8) pulses8++;
    endtask

    task automatic s3(input int v, input int d, input int c);
        cyc(v, d, c, 0, 0, 0, 0, 0);
    endtask

    task automatic reset3();
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        pulses3 = 0;
    endtask

    initial begin
        int idx;
        int v, d;

        rst3 = 1'b1; vld3 = 1'b0; din3 = 1'b0; ovl3 = 1'b0; clr3 = 1'b0;
        rst8 = 1'b1; vld8 = 1'b0; din8 = 1'b0; ovl8 = 1'b0; clr8 = 1'b0;
        pat3 = 3'b011; pat8 = 8'hA5;
        m3_bits = 0; m3_n = 0; m3_cnt = 0;
        m8_bits = 0; m8_n = 0; m8_cnt = 0;
        pulses3 = 0; pulses8 = 0;

        // reset state
        cyc(0, 0, 0, 1, 0, 0, 0, 1);
        cyc(1, 1, 1, 1, 1, 1, 1, 1);
        check("rst_dout3", int'(dout3), 0);
        check("rst_cnt3", int'(cnt3), 0);

        // 1: pattern 011, non-overlap, 0,1,1,0,1,1
        tag = "t1"; pat3 = 3'b011; ovl3 = 1'b0;
        reset3();
        foreach (s1[i]) s3(1, s1[i], 0);
        check("t1_pulses", pulses3, 2);
`ifdef SEQ_DET_CNT_EN
        check("t1_cnt", int'(cnt3), 2);
`endif

        // 2: pattern 101, overlap then non-overlap, 1,0,1,0,1
        tag = "t2o"; pat3 = 3'b101; ovl3 = 1'b1;
        reset3();
        foreach (s2[i]) s3(1, s2[i], 0);
        check("t2_ovl_pulses", pulses3, 2);
        tag = "t2n"; ovl3 = 1'b0;
        reset3();
        foreach (s2[i]) s3(1, s2[i], 0);
        check("t2_novl_pulses", pulses3, 1);

        // 3: gap in din_vld
        tag = "t3"; pat3 = 3'b011; ovl3 = 1'b0;
        reset3();
        s3(1, 0, 0);
        s3(1, 1, 0);
        for (int i = 0; i < 3; i++) s3(0, 1, 0);
        check("t3_gap_pulses", pulses3, 0);
        s3(1, 1, 0);
        check("t3_dout", int'(dout3), 1);
        s3(0, 0, 0);
        check("t3_dout_after", int'(dout3), 0);

        // 4: reset mid-stream discards history
        tag = "t4"; pat3 = 3'b011; ovl3 = 1'b0;
        reset3();
        s3(1, 0, 0);
        s3(1, 1, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        check("t4_rst_dout", int'(dout3), 0);
        check("t4_rst_cnt", int'(cnt3), 0);
        pulses3 = 0;
        foreach (s4[i]) s3(1, s4[i], 0);
        check("t4_pulses", pulses3, 1);
        check("t4_last_dout", int'(dout3), 1);

        // 5: saturation and clear-vs-match priority
        tag = "t5"; pat3 = 3'b111; ovl3 = 1'b1;
        reset3();
        for (int i = 0; i < 9; i++) s3(1, 1, 0);
        check("t5_pulses", pulses3, 7);
`ifdef SEQ_DET_CNT_EN
        check("t5_sat", int'(cnt3), 3);
`endif
        s3(1, 1, 1);
        check("t5_clr_dout", int'(dout3), 1);
        check("t5_clr_cnt", int'(cnt3), 0);

        // 6: PAT_W=8 random stream, pattern biased toward A5
        tag = "t6"; pat8 = 8'hA5; ovl8 = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        pulses8 = 0;
        idx = 0;
        for (int i = 0; i < 500; i++) begin
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if ($urandom_range(0, 3) != 0) d = int'(pat8[7 - idx]);
            else d = int'($urandom_range(0, 1));
            if (v != 0) idx = (idx + 1) % 8;
            if ($urandom_range(0, 31) == 0) ovl8 = ~ovl8;
            cyc(0, 0, 0, 0, v, d, ($urandom_range(0, 63) == 0) ? 1 : 0, 0);
        end
        check("t6_hits", (pulses8 > 0) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
